// File: rtl/hazard_unit_mc.sv
// Hazard detection and forwarding for the 5-stage MIPS pipeline, with
// mult/div busy tracking and a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              branch_d,
  input  logic              jump_d,
  input  logic              pc_src_d,
  input  logic              hilo_use_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              md_start_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic              reg_write_w,
  input  logic              cnt_clr,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              forward_ad,
  output logic              forward_bd,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              md_busy,
  output logic              md_done,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic {IDLE, BUSY} mdState_t;

  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 1);

  mdState_t   mdState, mdNextState;
  logic [3:0] mdCnt, mdNextCnt;
  logic       lwStall, branchStall, mdStall, anyStall;
  logic       eHitsD, mHitsD;

  // M-stage result has priority over W because it is the younger write
  always_comb begin
    forward_ae = 2'b00;
    forward_be = 2'b00;
    if (rs_e != '0 && rs_e == write_reg_m && reg_write_m)      forward_ae = 2'b10;
    else if (rs_e != '0 && rs_e == write_reg_w && reg_write_w) forward_ae = 2'b01;
    if (rt_e != '0 && rt_e == write_reg_m && reg_write_m)      forward_be = 2'b10;
    else if (rt_e != '0 && rt_e == write_reg_w && reg_write_w) forward_be = 2'b01;
  end

  assign forward_ad = (rs_d != '0) && (rs_d == write_reg_m) && reg_write_m;
  assign forward_bd = (rt_d != '0) && (rt_d == write_reg_m) && reg_write_m;

  assign lwStall = mem_to_reg_e && (rt_e != '0) && ((rs_d == rt_e) || (rt_d == rt_e));

  assign eHitsD = reg_write_e && (write_reg_e != '0) &&
                  ((write_reg_e == rs_d) || (write_reg_e == rt_d));
  assign mHitsD = mem_to_reg_m && (write_reg_m != '0) &&
                  ((write_reg_m == rs_d) || (write_reg_m == rt_d));
  assign branchStall = branch_d && (eHitsD || mHitsD);

  assign md_busy = (mdState == BUSY);
  assign md_done = md_busy && (mdCnt == 4'd0);
  // HI/LO consumer is released in the last busy cycle, when the result is ready
  assign mdStall = hilo_use_d && md_busy && !md_done;

  assign anyStall = lwStall | branchStall | mdStall;
  assign stall_f  = anyStall;
  assign stall_d  = anyStall;
  assign flush_e  = anyStall;
  assign flush_d  = (pc_src_d | jump_d) & ~anyStall;

  // Mult/div state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdState <= IDLE;
      mdCnt   <= 4'd0;
    end else begin
      mdState <= mdNextState;
      mdCnt   <= mdNextCnt;
    end
  end

  // Mult/div next state; a start while busy is ignored
  always_comb begin
    mdNextState = mdState;
    mdNextCnt   = mdCnt;
    case (mdState)
      IDLE: begin
        if (md_start_e) begin
          mdNextState = BUSY;
          mdNextCnt   = MD_INIT;
        end
      end
      BUSY: begin
        if (mdCnt == 4'd0) mdNextState = IDLE;
        else               mdNextCnt   = mdCnt - 4'd1;
      end
      default: begin
        mdNextState = IDLE;
        mdNextCnt   = 4'd0;
      end
    endcase
  end

  // Stall performance counter; clear beats increment, saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                stall_cycles <= '0;
    else if (cnt_clr)                       stall_cycles <= '0;
    else if (stall_d && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios plus random
// traffic compared against a behavioural model of the hazard rules.
module tb_hazard_unit_mc;

  localparam int AW      = 5;
  localparam int LAT     = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic          branch_d, jump_d, pc_src_d, hilo_use_d;
  logic          reg_write_e, mem_to_reg_e, md_start_e;
  logic          reg_write_m, mem_to_reg_m, reg_write_w, cnt_clr;
  logic [1:0]    forward_ae, forward_be;
  logic          forward_ad, forward_bd, stall_f, stall_d, flush_d, flush_e;
  logic          md_busy, md_done;
  logic [CW-1:0] stall_cycles;

  int testsRun  = 0;
  int failCount = 0;

  // Model state: cycles of mult/div work left, and the stall tally
  int mdRemain = 0;
  int stallCnt = 0;
  bit expStall;

  hazard_unit_mc #(.REG_AW(AW), .MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .jump_d(jump_d),
    .pc_src_d(pc_src_d), .hilo_use_d(hilo_use_d),
    .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .md_start_e(md_start_e),
    .write_reg_m(write_reg_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w), .cnt_clr(cnt_clr),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwdSel(input logic [AW-1:0] src);
    if (src != 0 && src == write_reg_m && reg_write_m) return 2'd2;
    if (src != 0 && src == write_reg_w && reg_write_w) return 2'd1;
    return 2'd0;
  endfunction

  // Compares every output against what the hazard rules predict right now
  task automatic checkOutput(input string step);
    bit lw, br, md, busy, done, redirect;
    busy = (mdRemain > 0);
    done = (mdRemain == 1);
    lw = mem_to_reg_e && rt_e != 0 && (rs_d == rt_e || rt_d == rt_e);
    br = branch_d && ((reg_write_e && write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                      (mem_to_reg_m && write_reg_m != 0 && (write_reg_m == rs_d || write_reg_m == rt_d)));
    md = hilo_use_d && busy && !done;
    expStall = lw || br || md;
    redirect = (pc_src_d || jump_d) && !expStall;
    checkVal({step, ".forward_ae"}, 32'(forward_ae), 32'(fwdSel(rs_e)));
    checkVal({step, ".forward_be"}, 32'(forward_be), 32'(fwdSel(rt_e)));
    checkVal({step, ".forward_ad"}, 32'(forward_ad), 32'(rs_d != 0 && rs_d == write_reg_m && reg_write_m));
    checkVal({step, ".forward_bd"}, 32'(forward_bd), 32'(rt_d != 0 && rt_d == write_reg_m && reg_write_m));
    checkVal({step, ".stall_f"}, 32'(stall_f), 32'(expStall));
    checkVal({step, ".stall_d"}, 32'(stall_d), 32'(expStall));
    checkVal({step, ".flush_e"}, 32'(flush_e), 32'(expStall));
    checkVal({step, ".flush_d"}, 32'(flush_d), 32'(redirect));
    checkVal({step, ".md_busy"}, 32'(md_busy), 32'(busy));
    checkVal({step, ".md_done"}, 32'(md_done), 32'(done));
    checkVal({step, ".stall_cycles"}, 32'(stall_cycles), 32'(stallCnt));
  endtask

  task automatic evalNow(input string step);
    @(negedge clk);
    checkOutput(step);
  endtask

  // Clock edge: advance the model the way the hardware is described to behave
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      mdRemain = 0;
      stallCnt = 0;
    end else begin
      if (cnt_clr) stallCnt = 0;
      else if (expStall && stallCnt < CNT_MAX) stallCnt++;
      if (mdRemain > 0) mdRemain--;
      else if (md_start_e) mdRemain = LAT;
    end
    #1;
  endtask

  task automatic stepCycle(input string step);
    evalNow(step);
    advance();
  endtask

  task automatic clearInputs();
    {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {branch_d, jump_d, pc_src_d, hilo_use_d} = '0;
    {reg_write_e, mem_to_reg_e, md_start_e} = '0;
    {reg_write_m, mem_to_reg_m, reg_write_w, cnt_clr} = '0;
  endtask

  // Small register range so that tag collisions happen often
  task automatic applyStimulus();
    rs_d = AW'($urandom_range(3)); rt_d = AW'($urandom_range(3));
    rs_e = AW'($urandom_range(3)); rt_e = AW'($urandom_range(3));
    write_reg_e = AW'($urandom_range(3));
    write_reg_m = AW'($urandom_range(3));
    write_reg_w = AW'($urandom_range(3));
    branch_d     = ($urandom_range(3) == 0);
    jump_d       = ($urandom_range(5) == 0);
    pc_src_d     = ($urandom_range(3) == 0);
    hilo_use_d   = $urandom_range(1);
    reg_write_e  = $urandom_range(1);
    mem_to_reg_e = ($urandom_range(3) == 0);
    md_start_e   = ($urandom_range(5) == 0);
    reg_write_m  = $urandom_range(1);
    mem_to_reg_m = ($urandom_range(3) == 0);
    reg_write_w  = $urandom_range(1);
    cnt_clr      = ($urandom_range(15) == 0);
  endtask

  initial begin
    int busyCycles, stallSeen, doneSeen;
    clearInputs();
    rst = 1'b1;
    #1;
    checkVal("reset.md_busy", 32'(md_busy), 32'd0);
    checkVal("reset.stall_cycles", 32'(stall_cycles), 32'd0);
    advance();
    advance();
    rst = 1'b0;

    // Forwarding priority and register zero
    rs_e = 3; write_reg_m = 3; reg_write_m = 1; write_reg_w = 3; reg_write_w = 1;
    evalNow("fwdM");
    checkVal("fwdM.const", 32'(forward_ae), 32'd2);
    advance();
    rs_e = 0;
    evalNow("fwdZero");
    checkVal("fwdZero.const", 32'(forward_ae), 32'd0);
    advance();
    reg_write_m = 0; rt_e = 3;
    stepCycle("fwdW");

    // Load-use stall, with a jump that the stall must suppress
    clearInputs();
    mem_to_reg_e = 1; rt_e = 5; rs_d = 5;
    evalNow("lwStall");
    checkVal("lwStall.const", 32'({stall_f, stall_d, flush_e}), 32'd7);
    advance();
    jump_d = 1;
    evalNow("lwJump");
    checkVal("lwJump.const", 32'(flush_d), 32'd0);
    advance();

    // Branch on an E result: stall once, then forward from M
    clearInputs();
    branch_d = 1; reg_write_e = 1; write_reg_e = 7; rt_d = 7;
    evalNow("brStall");
    checkVal("brStall.const", 32'(stall_d), 32'd1);
    advance();
    reg_write_e = 0; write_reg_e = 0; write_reg_m = 7; reg_write_m = 1; mem_to_reg_m = 0;
    evalNow("brFwd");
    checkVal("brFwd.fwd", 32'(forward_bd), 32'd1);
    checkVal("brFwd.stall", 32'(stall_d), 32'd0);
    advance();

    // Mult/div with a HI/LO consumer waiting in D
    clearInputs();
    md_start_e = 1;
    stepCycle("mdIssue");
    md_start_e = 0; hilo_use_d = 1;
    busyCycles = 0; stallSeen = 0; doneSeen = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      evalNow("mdRun");
      busyCycles += int'(md_busy);
      stallSeen  += int'(stall_d);
      doneSeen   += int'(md_done);
      if (md_done) checkVal("mdRun.doneLast", 32'(busyCycles), 32'(LAT));
      advance();
    end
    checkVal("mdRun.busyCycles", 32'(busyCycles), 32'(LAT));
    checkVal("mdRun.stallCycles", 32'(stallSeen), 32'(LAT - 1));
    checkVal("mdRun.doneCount", 32'(doneSeen), 32'd1);

    // Counter saturation and clear-over-increment
    clearInputs();
    cnt_clr = 1;
    stepCycle("satClr");
    cnt_clr = 0; mem_to_reg_e = 1; rt_e = 5; rs_d = 5;
    for (int i = 0; i < CNT_MAX + 5; i++) stepCycle("satRun");
    checkVal("sat.value", 32'(stall_cycles), 32'(CNT_MAX));
    cnt_clr = 1;
    stepCycle("satClrStall");
    checkVal("sat.cleared", 32'(stall_cycles), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      stepCycle("rand");
    end

    // Reset during the second busy cycle abandons the operation
    clearInputs();
    stepCycle("preRst");
    md_start_e = 1;
    stepCycle("rstIssue");
    md_start_e = 0; hilo_use_d = 1;
    stepCycle("rstBusy1");
    #2;
    rst = 1'b1;
    #1;
    checkVal("rstMid.md_busy", 32'(md_busy), 32'd0);
    checkVal("rstMid.md_done", 32'(md_done), 32'd0);
    checkVal("rstMid.stall_cycles", 32'(stall_cycles), 32'd0);
    mdRemain = 0;
    stallCnt = 0;
    stepCycle("rstHold");
    rst = 1'b0;
    hilo_use_d = 0;
    for (int i = 0; i < LAT + 1; i++) stepCycle("postRst");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
